// File: rtl/queue_pkg.sv
// Shared types and helpers for the dual-lane queue pointer controller.
package queue_pkg;

  localparam int LANES = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Number of set bits in a two-lane mask.
  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

  // Lane 1 only counts when lane 0 is also requesting.
  function automatic logic [1:0] thermo2(input logic [1:0] r);
    return {r[1] & r[0], r[0]};
  endfunction

endpackage

// File: rtl/ptr_adv.sv
// Advances a wrap-bit pointer by the popcount of an accepted lane mask and
// produces the two consecutive storage indices starting at the pointer.
module ptr_adv
  import queue_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic [AW:0]     ptr,
  input  logic [1:0]      mask,
  output logic [AW:0]     ptr_nxt,
  output logic [2*AW-1:0] idx
);

  logic [AW:0] step;
  logic [AW:0] ptr_p1;

  always_comb begin
    step      = '0;
    step[1:0] = popcount2(mask);
  end

  assign ptr_nxt = ptr + step;
  assign ptr_p1  = ptr + (AW+1)'(1);
  assign idx     = {ptr_p1[AW-1:0], ptr[AW-1:0]};

endmodule

// File: rtl/dual_queue_ctrl.sv
// Head/tail pointer and handshake controller for a 2-wide circular queue.
// Optional: define DUAL_QUEUE_CTRL_FULL_DEQ_EN to let same-cycle dequeues free space for enqueues.
module dual_queue_ctrl
  import queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_aN,
  input  logic             flush,
  input  logic [LANES-1:0] enq_req,
  output logic [LANES-1:0] enq_rdy,
  output logic [2*AW-1:0]  enq_idx,
  input  logic [LANES-1:0] deq_req,
  output logic [LANES-1:0] deq_vld,
  output logic [2*AW-1:0]  deq_idx,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  typedef logic [AW:0] ptr_t;

  localparam ptr_t          DEPTH_P = ptr_t'(DEPTH);
  localparam logic [AW+1:0] DEPTH_F = (AW+2)'(DEPTH);

  ptr_t          head_ptr, tail_ptr;
  ptr_t          head_nxt, tail_nxt;
  state_e        state, state_nxt;
  logic [AW+1:0] free;
  logic [1:0]    enq_rdy_run, deq_vld_run;
  logic [1:0]    enq_acc, deq_acc;

  assign count = tail_ptr - head_ptr;
  assign full  = (count == DEPTH_P);
  assign empty = (count == '0);

`ifdef DUAL_QUEUE_CTRL_FULL_DEQ_EN
  // Slots vacated by this cycle's dequeues are reusable by this cycle's enqueues.
  assign free = DEPTH_F - {1'b0, count} + (AW+2)'(popcount2(thermo2(deq_req) & deq_vld));
`else
  assign free = DEPTH_F - {1'b0, count};
`endif

  assign enq_rdy_run = {free > (AW+2)'(1), free > (AW+2)'(0)};
  assign deq_vld_run = {count > ptr_t'(1), count > ptr_t'(0)};

  // Flush blocks acceptance even while ready/valid still show RUN values.
  assign enq_acc = thermo2(enq_req) & enq_rdy & {2{~flush}};
  assign deq_acc = thermo2(deq_req) & deq_vld & {2{~flush}};

  always_ff @(posedge clk or negedge rst_aN) begin
    if (!rst_aN) state <= RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush)  state_nxt = FLUSH;
      FLUSH:   if (!flush) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    enq_rdy = '0;
    deq_vld = '0;
    if (state == RUN) begin
      enq_rdy = enq_rdy_run;
      deq_vld = deq_vld_run;
    end
  end

  ptr_adv #(.AW(AW)) u_head_adv (
    .ptr     (head_ptr),
    .mask    (deq_acc),
    .ptr_nxt (head_nxt),
    .idx     (deq_idx)
  );

  ptr_adv #(.AW(AW)) u_tail_adv (
    .ptr     (tail_ptr),
    .mask    (enq_acc),
    .ptr_nxt (tail_nxt),
    .idx     (enq_idx)
  );

  always_ff @(posedge clk or negedge rst_aN) begin
    if (!rst_aN) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      head_ptr <= head_nxt;
      tail_ptr <= tail_nxt;
    end
  end

  a_enq_thermo: assert property (@(posedge clk) disable iff (!rst_aN) enq_req != 2'b10)
    else $warning("dual_queue_ctrl: enq_req lane 1 without lane 0 is ignored");

  a_deq_thermo: assert property (@(posedge clk) disable iff (!rst_aN) deq_req != 2'b10)
    else $warning("dual_queue_ctrl: deq_req lane 1 without lane 0 is ignored");

endmodule

// File: tb/tb_dual_queue_ctrl.sv
// Bench for dual_queue_ctrl (DEPTH=4): occupancy-level reference model plus directed checks.
module tb_dual_queue_ctrl;

  localparam int D  = 4;
  localparam int AW = 2;
  localparam int PM = 2 * D;

  logic          clk = 1'b0;
  logic          rst_aN;
  logic          flush;
  logic [1:0]    enq_req, deq_req;
  logic [1:0]    enq_rdy, deq_vld;
  logic [2*AW-1:0] enq_idx, deq_idx;
  logic [AW:0]   count;
  logic          full, empty;

  int checks = 0;
  int errors = 0;

  int m_head, m_tail;
  bit m_flushing;

  always #5 clk = ~clk;

  dual_queue_ctrl #(.DEPTH(D)) dut (
    .clk     (clk),
    .rst_aN  (rst_aN),
    .flush   (flush),
    .enq_req (enq_req),
    .enq_rdy (enq_rdy),
    .enq_idx (enq_idx),
    .deq_req (deq_req),
    .deq_vld (deq_vld),
    .deq_idx (deq_idx),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requested lanes honoured: a lone lane-1 request counts as nothing.
  function automatic int nreq(input logic [1:0] r);
    return r[0] ? (r[1] ? 2 : 1) : 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int m_occ();
    return (m_tail - m_head + PM) % PM;
  endfunction

  function automatic int m_deq_n();
    return m_flushing ? 0 : imin(nreq(deq_req), m_occ());
  endfunction

  function automatic int m_space();
`ifdef DUAL_QUEUE_CTRL_FULL_DEQ_EN
    return m_flushing ? 0 : D - m_occ() + m_deq_n();
`else
    return m_flushing ? 0 : D - m_occ();
`endif
  endfunction

  function automatic int m_enq_n();
    return imin(nreq(enq_req), m_space());
  endfunction

  function automatic logic [3:0] idx_pair(input int p);
    logic [1:0] lo, hi;
    lo = 2'(p % D);
    hi = 2'((p + 1) % D);
    return {hi, lo};
  endfunction

  always @(posedge clk or negedge rst_aN) begin
    if (!rst_aN) begin
      m_head     <= 0;
      m_tail     <= 0;
      m_flushing <= 1'b0;
    end else if (flush) begin
      m_head     <= 0;
      m_tail     <= 0;
      m_flushing <= 1'b1;
    end else begin
      m_flushing <= 1'b0;
      m_head     <= (m_head + m_deq_n()) % PM;
      m_tail     <= (m_tail + m_enq_n()) % PM;
    end
  end

  always @(negedge clk) begin
    if (rst_aN === 1'b1) begin
      logic [1:0] exp_rdy, exp_vld;
      exp_rdy = {m_space() > 1, m_space() > 0};
      exp_vld = m_flushing ? 2'b00 : {m_occ() > 1, m_occ() > 0};
      chk("model count",   32'(count),   32'(m_occ()));
      chk("model full",    32'(full),    32'(m_occ() == D));
      chk("model empty",   32'(empty),   32'(m_occ() == 0));
      chk("model enq_rdy", 32'(enq_rdy), 32'(exp_rdy));
      chk("model deq_vld", 32'(deq_vld), 32'(exp_vld));
      chk("model enq_idx", 32'(enq_idx), 32'(idx_pair(m_tail)));
      chk("model deq_idx", 32'(deq_idx), 32'(idx_pair(m_head)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_aN  = 1'b0;
    flush   = 1'b0;
    enq_req = 2'b00;
    deq_req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_aN = 1'b1;

    chk("reset count",   32'(count),   32'd0);
    chk("reset empty",   32'(empty),   32'd1);
    chk("reset full",    32'(full),    32'd0);
    chk("reset enq_rdy", 32'(enq_rdy), 32'b11);
    chk("reset deq_vld", 32'(deq_vld), 32'b00);
    chk("reset enq_idx", 32'(enq_idx), 32'b0100);
    chk("reset deq_idx", 32'(deq_idx), 32'b0100);

    // Fill: 0 -> 2 -> 4
    enq_req = 2'b11;
    step();
    chk("fill count1", 32'(count), 32'd2);
    step();
    chk("fill count2",  32'(count),   32'd4);
    chk("fill full",    32'(full),    32'd1);
    chk("fill enq_rdy", 32'(enq_rdy), 32'b00);
    chk("fill enq_idx", 32'(enq_idx), 32'b0100);

    // Partial space: count 3, only lane 0 ready
    enq_req = 2'b00; deq_req = 2'b01;
    step();
    deq_req = 2'b00; enq_req = 2'b11;
    chk("partial count",   32'(count),   32'd3);
    chk("partial enq_rdy", 32'(enq_rdy), 32'b01);
    step();
    chk("partial count4", 32'(count), 32'd4);

    // Move head to 3 (tail 5), then simultaneous enq/deq with wrap
    enq_req = 2'b00; deq_req = 2'b01;
    step();
    step();
    chk("wrap pre deq_idx", 32'(deq_idx), 32'b0011);
    chk("wrap pre enq_idx", 32'(enq_idx), 32'b1001);
    chk("wrap pre count",   32'(count),   32'd2);
    enq_req = 2'b11; deq_req = 2'b11;
    step();
    chk("wrap count",   32'(count),   32'd2);
    chk("wrap deq_idx", 32'(deq_idx), 32'b1001);
    chk("wrap enq_idx", 32'(enq_idx), 32'b0011);

    // Full with a dequeue
    enq_req = 2'b11; deq_req = 2'b00;
    step();
    chk("fulldeq full", 32'(full), 32'd1);
    enq_req = 2'b01; deq_req = 2'b01;
    #1;
`ifdef DUAL_QUEUE_CTRL_FULL_DEQ_EN
    chk("fulldeq enq_rdy", 32'(enq_rdy), 32'b01);
    step();
    chk("fulldeq count", 32'(count), 32'd4);
    enq_req = 2'b00;
    step();
`else
    chk("fulldeq enq_rdy", 32'(enq_rdy), 32'b00);
    step();
    chk("fulldeq count", 32'(count), 32'd3);
`endif
    enq_req = 2'b00; deq_req = 2'b00;
    chk("preflush count", 32'(count), 32'd3);

    // Flush pulse with enqueue requests
    flush = 1'b1; enq_req = 2'b11;
    step();
    flush = 1'b0;
    chk("flush count",   32'(count),   32'd0);
    chk("flush enq_rdy", 32'(enq_rdy), 32'b00);
    chk("flush deq_vld", 32'(deq_vld), 32'b00);
    step();
    chk("postflush enq_rdy", 32'(enq_rdy), 32'b11);
    chk("postflush count",   32'(count),   32'd0);

    // Asynchronous reset mid-cycle
    step();
    enq_req = 2'b00;
    chk("prereset count", 32'(count), 32'd2);
    #2 rst_aN = 1'b0;
    #1;
    chk("async count", 32'(count), 32'd0);
    chk("async empty", 32'(empty), 32'd1);
    #2 rst_aN = 1'b1;
    step();

    // Lone lane-1 enqueue request is ignored
    enq_req = 2'b10;
    step();
    enq_req = 2'b00;
    chk("illegal count",   32'(count),   32'd0);
    chk("illegal enq_idx", 32'(enq_idx), 32'b0100);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int e, d;
      e = $urandom_range(0, 2);
      d = $urandom_range(0, 2);
      enq_req = (e == 2) ? 2'b11 : 2'(e);
      deq_req = (d == 2) ? 2'b11 : 2'(d);
      flush   = ($urandom_range(0, 24) == 0);
      step();
    end
    enq_req = 2'b00; deq_req = 2'b00; flush = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
